// File: rtl/yd_pkg.sv
// Shared definitions for the Yduck core: opcodes, register addresses, fetch defaults.
package yd_pkg;

   localparam int YD_AW = 16;
   localparam int YD_DW = 16;

   localparam logic [YD_DW-1:0] YD_NOP      = 16'h0000;
   localparam logic [YD_AW-1:0] YD_RESET_PC = 16'h0000;

   // Opcode field occupies instruction bits 15:12.
   localparam logic [3:0] NF = 4'h0;
   localparam logic [3:0] LD = 4'h1;
   localparam logic [3:0] ST = 4'h2;
   localparam logic [3:0] AD = 4'h3;
   localparam logic [3:0] SB = 4'h4;
   localparam logic [3:0] AN = 4'h5;
   localparam logic [3:0] OR = 4'h6;
   localparam logic [3:0] XR = 4'h7;
   localparam logic [3:0] SH = 4'h8;
   localparam logic [3:0] JP = 4'h9;
   localparam logic [3:0] JZ = 4'hA;
   localparam logic [3:0] CL = 4'hB;
   localparam logic [3:0] RT = 4'hC;
   localparam logic [3:0] IN = 4'hD;
   localparam logic [3:0] OU = 4'hE;
   localparam logic [3:0] TL = 4'hF;

   // Architectural register addresses.
   localparam logic [1:0] ZEA = 2'd0;
   localparam logic [1:0] DKA = 2'd1;
   localparam logic [1:0] R0A = 2'd2;
   localparam logic [1:0] PCA = 2'd3;

   function automatic logic [3:0] yd_opcode(input logic [YD_DW-1:0] word);
      return word[15:12];
   endfunction

endpackage

// File: rtl/yd_ifq.sv
// Prefetch queue: synchronous FIFO of {instruction, pc}; flush beats push and pop.
module yd_ifq
   import yd_pkg::*;
#(
   parameter int AW    = 16,
   parameter int DW    = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [DW-1:0]            push_inst,
   input  logic [AW-1:0]            push_pc,
   output logic [DW-1:0]            head_inst,
   output logic [AW-1:0]            head_pc,
   output logic                     head_valid,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DW-1:0] inst_q [DEPTH];
   logic [DW-1:0] inst_d [DEPTH];
   logic [AW-1:0] pc_q   [DEPTH];
   logic [AW-1:0] pc_d   [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_pop;

   // Next-state for storage, pointers and occupancy; pointers wrap naturally mod DEPTH.
   always_comb begin
      inst_d   = inst_q;
      pc_d     = pc_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      do_pop   = pop && (count_q != '0);
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            inst_d[wr_ptr_q] = push_inst;
            pc_d[wr_ptr_q]   = push_pc;
            wr_ptr_d         = wr_ptr_q + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(do_pop);
      end
   end

   // Queue registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            inst_q[i] <= '0;
            pc_q[i]   <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         inst_q   <= inst_d;
         pc_q     <= pc_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Head is muxed from registers only; an empty queue presents a NOP at pc 0.
   assign head_valid = (count_q != '0);
   assign head_inst  = head_valid ? inst_q[rd_ptr_q] : DW'(YD_NOP);
   assign head_pc    = head_valid ? pc_q[rd_ptr_q]   : '0;
   assign count      = count_q;

endmodule

// File: rtl/yd_ifetch.sv
// Instruction fetch: ROM request issue, single outstanding return, prefetch queue, jump redirect.
module yd_ifetch
   import yd_pkg::*;
#(
   parameter int            AW       = 16,
   parameter int            DW       = 16,
   parameter int            DEPTH    = 4,
   parameter logic [AW-1:0] RESET_PC = AW'(YD_RESET_PC)
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic [AW-1:0] i_addr,
   output logic          i_en,
   input  logic [DW-1:0] i_dout,
   input  logic          redirect,
   input  logic [AW-1:0] redirect_pc,
   output logic [DW-1:0] inst,
   output logic [AW-1:0] inst_pc,
   output logic          inst_valid,
   input  logic          inst_ready
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [AW-1:0] fetch_pc_q, fetch_pc_d;
   logic [AW-1:0] req_pc_q, req_pc_d;
   logic          inflight_q, inflight_d;
   logic [CW-1:0] q_count;
   logic [CW-1:0] occupancy;
   logic          issue;
   logic          q_push;
   logic          q_pop;

   // Issue gate counts the outstanding return as occupied so a return never meets a full queue.
   // Redirect suppresses issue and the pending return; the target is fetched next cycle.
   always_comb begin
      occupancy  = q_count + CW'(inflight_q);
      issue      = rst_n && !redirect && (occupancy < CW'(DEPTH));
      q_push     = inflight_q && !redirect;
      q_pop      = inst_valid && inst_ready;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      inflight_d = issue;
      if (redirect) begin
         fetch_pc_d = redirect_pc;
      end else if (issue) begin
         fetch_pc_d = fetch_pc_q + AW'(1);
         req_pc_d   = fetch_pc_q;
      end
   end

   // Fetch control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= RESET_PC;
         inflight_q <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
      end
   end

   assign i_en   = issue;
   assign i_addr = fetch_pc_q;

   yd_ifq #(
      .AW    (AW),
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_ifq (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (q_push),
      .pop        (q_pop),
      .flush      (redirect),
      .push_inst  (i_dout),
      .push_pc    (req_pc_q),
      .head_inst  (inst),
      .head_pc    (inst_pc),
      .head_valid (inst_valid),
      .count      (q_count)
   );

   a_no_full_return: assert property (@(posedge clk) disable iff (!rst_n)
      !(inflight_q && (q_count == CW'(DEPTH))));

endmodule

// File: tb/tb_yd_ifetch.sv
// Bench for yd_ifetch: expected PC stream queue fed by stimulus, popped by a negedge monitor.
module tb_yd_ifetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] i_addr;
   logic        i_en;
   logic [15:0] i_dout = 16'h0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = 16'h0;
   logic [15:0] inst;
   logic [15:0] inst_pc;
   logic        inst_valid;
   logic        inst_ready = 1'b1;

   int n_checks = 0;
   int n_errors = 0;
   int delivered = 0;

   logic [15:0] exp_q[$];
   logic [15:0] next_pc = 16'h0;

   yd_ifetch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_addr      (i_addr),
      .i_en        (i_en),
      .i_dout      (i_dout),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] rom(input logic [15:0] a);
      return a + 16'h0100;
   endfunction

   // ROM answers one cycle after a request; otherwise the bus holds garbage.
   always @(posedge clk) i_dout <= i_en ? rom(i_addr) : 16'hDEAD;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected stream is simply consecutive PCs from the last reset/redirect target.
   task automatic topup();
      while (exp_q.size() < 8) begin
         exp_q.push_back(next_pc);
         next_pc = next_pc + 16'h1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      topup();
   endtask

   task automatic do_redirect(input logic [15:0] tgt);
      redirect    = 1'b1;
      redirect_pc = tgt;
      exp_q.delete();
      next_pc = tgt;
      topup();
   endtask

   // Monitor: every accepted head must be the next expected PC with its ROM word.
   always @(negedge clk) begin
      if (rst_n) begin
         if (!inst_valid) begin
            check("empty_inst", 32'(inst), 32'h0);
            check("empty_pc", 32'(inst_pc), 32'h0);
         end else if (inst_ready && !redirect) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL scoreboard_underflow: got pc %0h expected none", inst_pc);
            end else begin
               logic [15:0] e;
               e = exp_q.pop_front();
               check("seq_pc", 32'(inst_pc), 32'(e));
               check("seq_inst", 32'(inst), 32'(rom(e)));
               delivered++;
            end
         end
      end
   end

   initial begin
      int w;
      exp_q.delete();
      next_pc = 16'h0;
      topup();
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(inst_valid), 32'h0);
      check("rst_inst", 32'(inst), 32'h0);
      check("rst_pc", 32'(inst_pc), 32'h0);
      check("rst_i_en", 32'(i_en), 32'h0);
      check("rst_i_addr", 32'(i_addr), 32'h0);

      // Release: issue now, valid two edges later.
      rst_n = 1'b1;
      #1;
      check("first_i_en", 32'(i_en), 32'h1);
      check("first_i_addr", 32'(i_addr), 32'h0);
      tick();
      check("lat_cycle1_valid", 32'(inst_valid), 32'h0);
      tick();
      check("lat_cycle2_valid", 32'(inst_valid), 32'h1);
      check("lat_cycle2_pc", 32'(inst_pc), 32'h0);
      check("lat_cycle2_inst", 32'(inst), 32'h0100);

      // Stall: queue fills, issue stops, head holds.
      inst_ready = 1'b0;
      repeat (10) tick();
      check("stall_i_en", 32'(i_en), 32'h0);
      check("stall_valid", 32'(inst_valid), 32'h1);
      check("stall_head", 32'(inst_pc), 32'(exp_q[0]));
      inst_ready = 1'b1;
      repeat (8) tick();

      // Redirect with a partly filled queue and a pop in the same cycle.
      inst_ready = 1'b0;
      repeat (2) tick();
      inst_ready = 1'b1;
      do_redirect(16'h0040);
      tick();
      redirect = 1'b0;
      check("redir_r1_valid", 32'(inst_valid), 32'h0);
      tick();
      check("redir_r2_valid", 32'(inst_valid), 32'h0);
      tick();
      check("redir_r3_valid", 32'(inst_valid), 32'h1);
      check("redir_r3_pc", 32'(inst_pc), 32'h0040);
      repeat (4) tick();

      // Random ready and redirects, including back-to-back and wrap targets.
      for (int i = 0; i < 400; i++) begin
         inst_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0)
            do_redirect(($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom));
         else
            redirect = 1'b0;
         tick();
      end
      redirect = 1'b0;
      check("throughput_min", 32'(delivered > 60), 32'h1);

      // Address wrap at full rate.
      inst_ready = 1'b1;
      do_redirect(16'hFFFE);
      tick();
      redirect = 1'b0;
      repeat (2) tick();
      check("wrap_pc0", 32'(inst_pc), 32'hFFFE);
      tick();
      check("wrap_pc1", 32'(inst_pc), 32'hFFFF);
      tick();
      check("wrap_pc2", 32'(inst_pc), 32'h0000);
      tick();
      check("wrap_pc3", 32'(inst_pc), 32'h0001);
      repeat (3) tick();

      // Reset mid-stream with a request outstanding.
      check("pre_reset_i_en", 32'(i_en), 32'h1);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 32'(inst_valid), 32'h0);
      check("midrst_inst", 32'(inst), 32'h0);
      check("midrst_pc", 32'(inst_pc), 32'h0);
      check("midrst_i_en", 32'(i_en), 32'h0);
      exp_q.delete();
      next_pc = 16'h0;
      topup();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      w = 0;
      while (!inst_valid && w < 20) begin
         tick();
         w++;
      end
      check("restart_valid", 32'(inst_valid), 32'h1);
      check("restart_pc", 32'(inst_pc), 32'h0);
      check("restart_latency", 32'(w), 32'h2);
      repeat (10) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
